// File: rtl/sram_port_arb.sv
// Round-robin arbiter with burst lock giving NREQ requesters access to one single-port word SRAM.
// Optional wait-age preemption is compiled in with `define SRAM_ARB_AGE_EN.
module sram_port_arb #(
  parameter int NREQ     = 3,
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8,
  parameter int AGE_MAX  = 15
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*(DW/8)-1:0] we,
  input  logic [NREQ*AW-1:0]     addr,
  input  logic [NREQ*DW-1:0]     wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DW-1:0]          rdata,
  output logic                   sram_cs,
  output logic [DW/8-1:0]        sram_we,
  output logic [AW-1:0]          sram_a,
  output logic [DW-1:0]          sram_di,
  input  logic [DW-1:0]          sram_do
);

  localparam int BW = DW / 8;
  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("sram_port_arb: NREQ must be 2..4");
  end
  if (AGE_MAX < 1 || LOCK_MAX < 1) begin : g_bad_limits
    $error("sram_port_arb: AGE_MAX and LOCK_MAX must be at least 1");
  end

  logic [PW-1:0]   rr_ptr, rr_next;
  logic            lock_vld, lock_vld_next;
  logic [PW-1:0]   lock_own, lock_own_next;
  logic [CW-1:0]   lock_cnt, lock_cnt_next, cnt_inc;
  logic [NREQ-1:0] rv_q;
  logic            found, held;
  logic [PW-1:0]   win, win_inc;
  int              idx;

`ifdef SRAM_ARB_AGE_EN
  localparam int AGW = $clog2(AGE_MAX + 1);
  logic [AGW-1:0]  age_q [NREQ];
  logic [NREQ-1:0] aged;

  always_comb begin
    for (int i = 0; i < NREQ; i++) aged[i] = (age_q[i] == AGW'(AGE_MAX));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rstn || !req[i] || gnt[i]) age_q[i] <= '0;
      else if (!aged[i])              age_q[i] <= age_q[i] + 1'b1;
    end
  end
`endif

  // Winner priority: saturated age (if built) > live lock owner > first request from rr_ptr.
  always_comb begin
    found = 1'b0;
    held  = 1'b0;
    win   = '0;
    idx   = 0;
`ifdef SRAM_ARB_AGE_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (aged[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
`endif
    if (!found && lock_vld && req[lock_own]) begin
      found = 1'b1;
      held  = 1'b1;
      win   = lock_own;
    end
    if (!found) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx]) begin
          found = 1'b1;
          win   = PW'(idx);
        end
      end
    end
    if (!rstn) begin
      found = 1'b0;
      held  = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[win] = 1'b1;
    sram_cs = found;
    sram_a  = found ? addr[int'(win)*AW +: AW]  : '0;
    sram_we = found ? we[int'(win)*BW +: BW]    : '0;
    sram_di = found ? wdata[int'(win)*DW +: DW] : '0;
  end

  // Lock bookkeeping; the beat that reaches LOCK_MAX is granted, then rotation is forced.
  always_comb begin
    win_inc       = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    cnt_inc       = held ? lock_cnt + 1'b1 : CW'(1);
    rr_next       = rr_ptr;
    lock_vld_next = 1'b0;
    lock_own_next = lock_own;
    lock_cnt_next = '0;
    if (found) begin
      if (!held) rr_next = win_inc;
      if (lock[win]) begin
        if (cnt_inc >= CW'(LOCK_MAX)) begin
          rr_next = win_inc;
        end else begin
          lock_vld_next = 1'b1;
          lock_own_next = win;
          lock_cnt_next = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_own <= '0;
      lock_cnt <= '0;
      rv_q     <= '0;
    end else begin
      rr_ptr   <= rr_next;
      lock_vld <= lock_vld_next;
      lock_own <= lock_own_next;
      lock_cnt <= lock_cnt_next;
      rv_q     <= (|sram_we) ? '0 : gnt;
    end
  end

  // Gating with rstn keeps a read granted just before reset from returning during it.
  assign rvalid = rv_q & {NREQ{rstn}};
  assign rdata  = (|rvalid) ? sram_do : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb: behavioural SRAM model, grant/read-return scoreboard.
module tb_sram_port_arb;

  localparam int NREQ = 3;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int GW   = 1 + NREQ + AW + BW + DW;
  localparam int RW   = NREQ + DW;

  localparam logic [31:0] D0 = 32'hA5A5_0010;
  localparam logic [31:0] D1 = 32'h5A5A_0020;
  localparam logic [31:0] D2 = 32'hC3C3_0030;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, lock, gnt, rvalid;
  logic [NREQ*BW-1:0] we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0]      rdata, sram_di, sram_do;
  logic               sram_cs;
  logic [BW-1:0]      sram_we;
  logic [AW-1:0]      sram_a;

  logic [AW-1:0] addr_v  [NREQ];
  logic [BW-1:0] we_v    [NREQ];
  logic [DW-1:0] wdata_v [NREQ];

  assign addr  = {addr_v[2], addr_v[1], addr_v[0]};
  assign we    = {we_v[2], we_v[1], we_v[0]};
  assign wdata = {wdata_v[2], wdata_v[1], wdata_v[0]};

  sram_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(8), .AGE_MAX(15)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (sram_cs) begin
      if (|sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_we[b]) mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
      end else begin
        sram_do <= mem[sram_a];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [GW-1:0] exp_gnt_q [$];
  logic [RW-1:0] exp_rd_q  [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic [GW-1:0] mon_g;
  logic [RW-1:0] mon_r;

  always @(negedge clk) begin
    if (|gnt) begin
      if (exp_gnt_q.size() == 0) begin
        check("unexpected_gnt", 64'(gnt), 64'd0);
      end else begin
        mon_g = exp_gnt_q.pop_front();
        check("grant", 64'({sram_cs, gnt, sram_a, sram_we, sram_di}), 64'(mon_g));
      end
    end else begin
      check("idle_sram", 64'({sram_cs, sram_we, sram_a, sram_di}), 64'd0);
    end
    if (|rvalid) begin
      if (exp_rd_q.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        mon_r = exp_rd_q.pop_front();
        check("read_return", 64'({rvalid, rdata}), 64'(mon_r));
      end
    end else begin
      check("rdata_idle", 64'(rdata), 64'd0);
    end
  end

  // ---------------- driver ----------------
  // One cycle of stimulus; eg is the hand-computed one-hot grant, erd the data a read must return.
  task automatic step(input logic [2:0] r, input logic [2:0] lk, input logic [2:0] eg,
                      input logic [31:0] erd);
    int w;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req  = r;
    lock = lk;
    if (eg != 3'b000) begin
      w = 0;
      for (int k = 0; k < NREQ; k++) if (eg[k]) w = k;
      exp_gnt_q.push_back({1'b1, eg, addr_v[w], we_v[w], wdata_v[w]});
      if (we_v[w] == '0) exp_rd_q.push_back({eg, erd});
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[14'h010] = D0;
    mem[14'h020] = D1;
    mem[14'h030] = D2;
    mem[14'h3FF] = 32'hDEADBEEF;
    mem[14'h400] = 32'h11223344;
    addr_v[0] = 14'h010; addr_v[1] = 14'h020; addr_v[2] = 14'h030;
    for (int i = 0; i < NREQ; i++) begin
      we_v[i]    = '0;
      wdata_v[i] = '0;
    end
    req  = 3'b111;
    lock = 3'b000;
    rstn = 1'b0;

    // reset state with all requesters asserting
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_rvalid", 64'(rvalid), 64'd0);
    check("reset_cs_we", 64'({sram_cs, sram_we}), 64'd0);

    // all three request, no lock: 0,1,2,0,1,2
    step(3'b111, 3'b000, 3'b001, D0);
    step(3'b111, 3'b000, 3'b010, D1);
    step(3'b111, 3'b000, 3'b100, D2);
    step(3'b111, 3'b000, 3'b001, D0);
    step(3'b111, 3'b000, 3'b010, D1);
    step(3'b111, 3'b000, 3'b100, D2);
    step(3'b000, 3'b000, 3'b000, 32'h0);

    // single read from requester 1
    addr_v[1] = 14'h3FF;
    step(3'b010, 3'b000, 3'b010, 32'hDEADBEEF);
    step(3'b000, 3'b000, 3'b000, 32'h0);
    addr_v[1] = 14'h020;

    // byte-lane write from requester 2
    addr_v[2] = 14'h400; we_v[2] = 4'b0100; wdata_v[2] = 32'h00AB0000;
    step(3'b100, 3'b000, 3'b100, 32'h0);
    step(3'b000, 3'b000, 3'b000, 32'h0);
    addr_v[2] = 14'h030; we_v[2] = 4'b0000; wdata_v[2] = 32'h0;

    // locked burst from 0 while 1 waits: 8 grants to 0, then forced rotation to 1
    for (int i = 0; i < 8; i++) step(3'b011, 3'b001, 3'b001, D0);
    step(3'b011, 3'b001, 3'b010, D1);
    step(3'b001, 3'b001, 3'b001, D0);
    step(3'b000, 3'b000, 3'b000, 32'h0);

    // locked 0 versus waiting 2: 2 wins on the 9th cycle
    step(3'b100, 3'b000, 3'b100, D2);
    for (int i = 0; i < 8; i++) step(3'b101, 3'b001, 3'b001, D0);
    step(3'b101, 3'b001, 3'b100, D2);
    step(3'b000, 3'b000, 3'b000, 32'h0);

    // reset the cycle after a read grant: the read never returns
    step(3'b010, 3'b000, 3'b010, D1);
    void'(exp_rd_q.pop_back());
    @(posedge clk);
    #1;
    rstn = 1'b0;
    req  = 3'b110;
    @(negedge clk);
    check("rst_mid_rvalid", 64'(rvalid), 64'd0);
    check("rst_mid_gnt", 64'(gnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rvalid2", 64'(rvalid), 64'd0);
    #1;
    step(3'b110, 3'b000, 3'b010, D1);
    step(3'b100, 3'b000, 3'b100, D2);
    repeat (3) step(3'b000, 3'b000, 3'b000, 32'h0);

    check("mem_byte_write", 64'(mem[14'h400]), 64'h11AB3344);
    check("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
